// File: rtl/pc_btb_unit_if.sv
// Execute-side resolution bus and fetch-side prediction outputs of the PC/BTB unit.
// The slave side is the unit; the master side is the pipeline around it.
interface pc_btb_unit_if #(
    parameter int DATA_W = 64,
    parameter int CNT_W  = 32
);
    logic              resolve_valid;
    logic [DATA_W-1:0] resolve_pc;
    logic              resolve_taken;
    logic [DATA_W-1:0] resolve_target;
    logic              resolve_pred_taken;
    logic [DATA_W-1:0] resolve_pred_target;
    logic [DATA_W-1:0] current_pc;
    logic              pred_taken;
    logic [DATA_W-1:0] pred_target;
    logic              mispredict;
    logic [CNT_W-1:0]  mispredict_count;

    modport master (
        output resolve_valid, resolve_pc, resolve_taken, resolve_target,
               resolve_pred_taken, resolve_pred_target,
        input  current_pc, pred_taken, pred_target, mispredict, mispredict_count
    );

    modport slave (
        input  resolve_valid, resolve_pc, resolve_taken, resolve_target,
               resolve_pred_taken, resolve_pred_target,
        output current_pc, pred_taken, pred_target, mispredict, mispredict_count
    );
endinterface

// File: rtl/pc_btb_unit.sv
// Fetch PC register with a direct-mapped BTB (2-bit saturating counters),
// execute-stage resolution, mispredict redirect and a saturating mispredict counter.
module pc_btb_unit #(
    parameter int                DATA_W      = 64,
    parameter int                BTB_ENTRIES = 16,
    parameter logic [DATA_W-1:0] RESET_PC    = '0,
    parameter int                CNT_W       = 32
) (
    input  logic          clk,
    input  logic          arst_n,
    input  logic          enable,
    input  logic          stall,
    pc_btb_unit_if.slave  bus
);
    localparam int                IDX_W   = $clog2(BTB_ENTRIES);
    localparam int                TAG_W   = DATA_W - 2 - IDX_W;
    localparam logic [DATA_W-1:0] PC_STEP = DATA_W'(4);

    function automatic logic [1:0] ctr_inc(input logic [1:0] c);
        return (c == 2'b11) ? c : c + 2'b01;
    endfunction

    function automatic logic [1:0] ctr_dec(input logic [1:0] c);
        return (c == 2'b00) ? c : c - 2'b01;
    endfunction

    function automatic logic [CNT_W-1:0] cnt_sat_inc(input logic [CNT_W-1:0] c);
        return (&c) ? c : c + CNT_W'(1);
    endfunction

    logic [BTB_ENTRIES-1:0] valid_q;
    logic [1:0]             ctr_q [BTB_ENTRIES];
    logic [TAG_W-1:0]       tag_q [BTB_ENTRIES];
    logic [DATA_W-1:0]      tgt_q [BTB_ENTRIES];
    logic [DATA_W-1:0]      pc_q;
    logic [CNT_W-1:0]       cnt_q;

    logic [IDX_W-1:0]  f_idx;
    logic [TAG_W-1:0]  f_tag;
    logic              f_hit;
    logic              f_taken;
    logic [DATA_W-1:0] f_next;

    logic [IDX_W-1:0]  r_idx;
    logic [TAG_W-1:0]  r_tag;
    logic              r_hit;
    logic              upd_en;
    logic [DATA_W-1:0] r_seq;
    logic [DATA_W-1:0] actual_next;
    logic [DATA_W-1:0] predicted_next;
    logic              mispredict;

    // Fetch-side lookup always reads pre-edge BTB contents.
    assign f_idx   = pc_q[2 +: IDX_W];
    assign f_tag   = pc_q[DATA_W-1 -: TAG_W];
    assign f_hit   = valid_q[f_idx] && (tag_q[f_idx] == f_tag);
    assign f_taken = f_hit && ctr_q[f_idx][1];
    assign f_next  = f_taken ? tgt_q[f_idx] : pc_q + PC_STEP;

    assign r_idx          = bus.resolve_pc[2 +: IDX_W];
    assign r_tag          = bus.resolve_pc[DATA_W-1 -: TAG_W];
    assign r_hit          = valid_q[r_idx] && (tag_q[r_idx] == r_tag);
    assign upd_en         = enable && bus.resolve_valid;
    assign r_seq          = bus.resolve_pc + PC_STEP;
    assign actual_next    = bus.resolve_taken ? bus.resolve_target : r_seq;
    assign predicted_next = bus.resolve_pred_taken ? bus.resolve_pred_target : r_seq;
    assign mispredict     = upd_en && (actual_next != predicted_next);

    assign bus.current_pc       = pc_q;
    assign bus.pred_taken       = f_taken;
    assign bus.pred_target      = f_next;
    assign bus.mispredict       = mispredict;
    assign bus.mispredict_count = cnt_q;

    // Control state: PC, statistics, valid bits and counters.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            pc_q    <= RESET_PC;
            cnt_q   <= '0;
            valid_q <= '0;
            for (int i = 0; i < BTB_ENTRIES; i++) begin
                ctr_q[i] <= 2'b01;
            end
        end else if (enable) begin
            // A redirect overrides a stall so the flush is never lost.
            if (mispredict) begin
                pc_q  <= actual_next;
                cnt_q <= cnt_sat_inc(cnt_q);
            end else if (!stall) begin
                pc_q <= f_next;
            end
            if (bus.resolve_valid) begin
                if (bus.resolve_taken) begin
                    valid_q[r_idx] <= 1'b1;
                    ctr_q[r_idx]   <= r_hit ? ctr_inc(ctr_q[r_idx]) : 2'b10;
                end else if (r_hit) begin
                    ctr_q[r_idx] <= ctr_dec(ctr_q[r_idx]);
                end
            end
        end
    end

    // Tag/target payload needs no reset; valid_q masks stale contents.
    always_ff @(posedge clk) begin
        if (upd_en && bus.resolve_taken) begin
            tag_q[r_idx] <= r_tag;
            tgt_q[r_idx] <= bus.resolve_target;
        end
    end
endmodule

// File: tb/tb_pc_btb_unit.sv
// Directed bench for pc_btb_unit: sequencing, stall, BTB training/hysteresis,
// aliasing, redirect under stall, enable gating, async reset and PC wrap.
module tb_pc_btb_unit;
    logic clk = 1'b0;
    logic arst_n;
    logic enable;
    logic stall;
    int   checks = 0;
    int   errors = 0;

    pc_btb_unit_if #(.DATA_W(64), .CNT_W(32)) bus ();

    pc_btb_unit #(
        .DATA_W(64), .BTB_ENTRIES(16), .RESET_PC(64'h0), .CNT_W(32)
    ) dut (
        .clk    (clk),
        .arst_n (arst_n),
        .enable (enable),
        .stall  (stall),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_res(input logic [63:0] pc, input logic tk, input logic [63:0] tgt,
                           input logic ptk, input logic [63:0] ptgt);
        bus.resolve_valid       = 1'b1;
        bus.resolve_pc          = pc;
        bus.resolve_taken       = tk;
        bus.resolve_target      = tgt;
        bus.resolve_pred_taken  = ptk;
        bus.resolve_pred_target = ptgt;
        #1;
    endtask

    task automatic clr_res();
        bus.resolve_valid      = 1'b0;
        bus.resolve_taken      = 1'b0;
        bus.resolve_pred_taken = 1'b0;
        #1;
    endtask

    // Redirect the PC by resolving a not-taken op at to-4 that was predicted to jump away.
    task automatic redirect(input logic [63:0] to, input logic [31:0] exp_cnt);
        set_res(to - 64'd4, 1'b0, 64'h0, 1'b1, 64'h1000);
        chk("redir_mispredict", {63'h0, bus.mispredict}, 64'h1);
        step();
        clr_res();
        chk("redir_pc", bus.current_pc, to);
        chk("redir_cnt", {32'h0, bus.mispredict_count}, {32'h0, exp_cnt});
    endtask

    initial begin
        arst_n = 1'b0;
        enable = 1'b0;
        stall  = 1'b0;
        bus.resolve_pc = '0;
        bus.resolve_target = '0;
        bus.resolve_pred_target = '0;
        clr_res();
        #2;
        chk("rst_pc", bus.current_pc, 64'h0);
        chk("rst_pred_taken", {63'h0, bus.pred_taken}, 64'h0);
        chk("rst_pred_target", bus.pred_target, 64'h4);
        chk("rst_mispredict", {63'h0, bus.mispredict}, 64'h0);
        chk("rst_cnt", {32'h0, bus.mispredict_count}, 64'h0);
        step();
        arst_n = 1'b1;
        enable = 1'b1;
        #1;
        chk("seq_pc0", bus.current_pc, 64'h0);
        step(); chk("seq_pc4", bus.current_pc, 64'h4);
        step(); chk("seq_pc8", bus.current_pc, 64'h8);

        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step(); chk("stall_hold", bus.current_pc, 64'h8);
        end
        stall = 1'b0;
        step(); chk("stall_release", bus.current_pc, 64'hC);
        chk("seq_pred_taken", {63'h0, bus.pred_taken}, 64'h0);
        chk("seq_cnt", {32'h0, bus.mispredict_count}, 64'h0);

        // First taken resolve at 0x10 allocates the entry with ctr=10.
        set_res(64'h10, 1'b1, 64'h40, 1'b0, 64'h0);
        chk("alloc_mispredict", {63'h0, bus.mispredict}, 64'h1);
        step(); clr_res();
        chk("alloc_pc", bus.current_pc, 64'h40);
        chk("alloc_cnt", {32'h0, bus.mispredict_count}, 64'h1);
        chk("miss_at_40", bus.pred_target, 64'h44);
        redirect(64'h10, 32'd2);
        chk("hit10_taken", {63'h0, bus.pred_taken}, 64'h1);
        chk("hit10_target", bus.pred_target, 64'h40);
        step(); chk("follow_pred", bus.current_pc, 64'h40);

        // Hysteresis: 10 -> 11 -> 10 -> 01.
        set_res(64'h10, 1'b1, 64'h40, 1'b1, 64'h40);
        chk("correct_no_mp", {63'h0, bus.mispredict}, 64'h0);
        step(); chk("correct_pc", bus.current_pc, 64'h44);
        set_res(64'h10, 1'b0, 64'h0, 1'b1, 64'h40);
        chk("nt1_mispredict", {63'h0, bus.mispredict}, 64'h1);
        step(); chk("nt1_pc", bus.current_pc, 64'h14);
        chk("nt1_cnt", {32'h0, bus.mispredict_count}, 64'h3);
        #1; chk("nt2_mispredict", {63'h0, bus.mispredict}, 64'h1);
        step(); clr_res();
        chk("nt2_cnt", {32'h0, bus.mispredict_count}, 64'h4);
        redirect(64'h10, 32'd5);
        chk("weak_nt_taken", {63'h0, bus.pred_taken}, 64'h0);
        chk("weak_nt_target", bus.pred_target, 64'h14);

        // Retrain to weak-taken; same-cycle lookup still sees ctr=01.
        set_res(64'h10, 1'b1, 64'h40, 1'b1, 64'h40);
        chk("retrain_no_mp", {63'h0, bus.mispredict}, 64'h0);
        step(); clr_res();
        chk("preedge_lookup_pc", bus.current_pc, 64'h14);
        redirect(64'h10, 32'd6);
        chk("retrained_taken", {63'h0, bus.pred_taken}, 64'h1);

        // Aliasing: 0x50 shares index 4 with 0x10.
        redirect(64'h50, 32'd7);
        chk("alias_miss", {63'h0, bus.pred_taken}, 64'h0);
        chk("alias_target", bus.pred_target, 64'h54);
        set_res(64'h50, 1'b1, 64'h80, 1'b0, 64'h0);
        chk("alias_mispredict", {63'h0, bus.mispredict}, 64'h1);
        step(); clr_res();
        chk("alias_pc", bus.current_pc, 64'h80);
        redirect(64'h10, 32'd9);
        chk("evicted_10", {63'h0, bus.pred_taken}, 64'h0);
        redirect(64'h50, 32'd10);
        chk("owner_50_taken", {63'h0, bus.pred_taken}, 64'h1);
        chk("owner_50_target", bus.pred_target, 64'h80);

        // Redirect wins over stall.
        stall = 1'b1;
        set_res(64'h100, 1'b1, 64'h200, 1'b0, 64'h0);
        chk("stall_mp", {63'h0, bus.mispredict}, 64'h1);
        step(); clr_res();
        chk("stall_redirect_pc", bus.current_pc, 64'h200);
        step(); chk("stall_after_redirect", bus.current_pc, 64'h200);
        stall = 1'b0;

        // enable=0 freezes everything and masks mispredict.
        enable = 1'b0;
        set_res(64'h300, 1'b1, 64'h500, 1'b0, 64'h0);
        chk("dis_mispredict", {63'h0, bus.mispredict}, 64'h0);
        step(); clr_res();
        chk("dis_pc", bus.current_pc, 64'h200);
        chk("dis_cnt", {32'h0, bus.mispredict_count}, 64'd11);
        chk("dis_lookup", bus.pred_target, 64'h204);
        enable = 1'b1;

        // Asynchronous reset mid-cycle.
        arst_n = 1'b0;
        #1;
        chk("arst_pc", bus.current_pc, 64'h0);
        chk("arst_cnt", {32'h0, bus.mispredict_count}, 64'h0);
        arst_n = 1'b1;
        redirect(64'h50, 32'd1);
        chk("arst_btb_cleared", {63'h0, bus.pred_taken}, 64'h0);

        // PC+4 wraps modulo 2^64.
        redirect(64'hFFFF_FFFF_FFFF_FFFC, 32'd2);
        chk("wrap_target", bus.pred_target, 64'h0);
        step(); chk("wrap_pc", bus.current_pc, 64'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/pc_btb_unit.md
Name: pc_btb_unit

Overview:
- Parametrised successor to the fetch-side PC logic.
- Holds the program counter and a direct-mapped branch target buffer (BTB) with 2-bit saturating counters.
- Predicts the next fetch address each cycle, accepts branch/jump resolution from the execute stage, and redirects the PC on a mispredict.
- Intended for the pipelined CPU generation. It drives the instruction memory address and the pipeline flush.

Parameters:
DATA_W, 64, PC/target width in bits
BTB_ENTRIES, 16, number of BTB entries; power of two, >=2
RESET_PC, 0, PC value loaded at reset
CNT_W, 32, width of the mispredict statistics counter

Ports:
clk  input  1  main clock
arst_n  input  1  asynchronous active-low reset
enable  input  1  starts execution; 0 freezes the PC, the BTB and the statistics counter
stall  input  1  hold current_pc (pipeline stall)
resolve_valid  input  1  a branch/jump resolves this cycle
resolve_pc  input  DATA_W  PC of the resolving instruction
resolve_taken  input  1  actual outcome (jumps are always 1)
resolve_target  input  DATA_W  actual taken target
resolve_pred_taken  input  1  prediction carried down the pipe with the instruction
resolve_pred_target  input  DATA_W  predicted next PC carried with the instruction
current_pc  output  DATA_W  fetch address
pred_taken  output  1  prediction for current_pc
pred_target  output  DATA_W  predicted next PC for current_pc
mispredict  output  1  flush request (combinational)
mispredict_count  output  CNT_W  saturating count of mispredicts

Behaviour:
- IDX_W = log2(BTB_ENTRIES).
- Index = pc[2 +: IDX_W]; tag = pc[DATA_W-1 : 2+IDX_W].
- Entry = {valid, tag, target, ctr[1:0]}.
- Counter encoding: 00 strong not-taken, 01 weak not-taken, 10 weak taken, 11 strong taken.
- Reset (async, arst_n=0):
  - current_pc=RESET_PC, mispredict_count=0.
  - All entries valid=0, ctr=01.
  - Resulting outputs: pred_taken=0, pred_target=RESET_PC+4, mispredict=0.
- Lookup (combinational on current_pc):
  - hit = valid & tag match.
  - pred_taken = hit & ctr[1].
  - pred_target = pred_taken ? entry target : current_pc+4.
- Mispredict (combinational):
  - actual_next = resolve_taken ? resolve_target : resolve_pc+4.
  - predicted_next = resolve_pred_taken ? resolve_pred_target : resolve_pc+4.
  - mispredict = enable & resolve_valid & (actual_next != predicted_next).
- PC update at posedge when enable=1, priority order:
  - mispredict: current_pc <= actual_next. This applies even if stall=1.
  - else stall: hold.
  - else: current_pc <= pred_target.
- BTB update at posedge when enable & resolve_valid, at the index of resolve_pc:
  - taken, hit: target <= resolve_target; ctr saturating increment.
  - taken, miss: allocate/overwrite. valid=1, tag, target, ctr=10.
  - not taken, hit: ctr saturating decrement; valid, tag and target unchanged.
  - not taken, miss: no change.
- Same-cycle lookup and update of the same index: lookup sees pre-edge contents. The update is visible the following cycle.
- mispredict_count increments on each cycle with mispredict=1 and saturates at all-ones (no wrap).
- PC arithmetic is modulo 2^DATA_W. current_pc+4 wraps silently.
- enable=0:
  - PC, BTB and counter hold.
  - mispredict=0.
  - Lookup outputs remain valid.
- Reset asserted mid-operation: all state cleared immediately. No partial BTB write survives.

Test Plan:
- Reset then enable=1, no resolves -> current_pc 0x0,0x4,0x8,0xC on successive cycles; pred_taken=0; mispredict_count=0.
- stall=1 for 3 cycles at current_pc=0x8 -> current_pc stays 0x8 for 3 cycles, then 0xC after stall drops.
- Resolve pc=0x10 taken target=0x40, pred_taken=0 -> mispredict=1 that cycle; next current_pc=0x40; mispredict_count=1. A later fetch at 0x10 -> pred_taken=1, pred_target=0x40.
- Counter hysteresis at 0x10:
  - A correct taken resolve (pred 0x40) -> ctr=11, no mispredict.
  - Then two not-taken resolves with pred_taken=1 -> ctr 10 then 01, mispredict=1 each time.
  - Next fetch of 0x10 -> pred_taken=0, pred_target=0x14.
- Aliasing with BTB_ENTRIES=16: 0x10 valid; fetch 0x50 (same index, different tag) -> pred_taken=0. Taken resolve at 0x50 target 0x80 -> entry overwritten; fetch 0x10 now misses.
- Mispredict with stall=1 and simultaneous resolve -> PC redirected to actual_next despite stall. Then arst_n pulse -> current_pc=RESET_PC, fetch 0x50 misses, mispredict_count=0.
